// File: rtl/apb_initiator_bridge_if.sv
// Request/response channel and APB initiator bundle for apb_initiator_bridge.
// master = bridge side, slave = core adapter plus APB responder side.
interface apb_initiator_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              in_req_valid;
  logic              in_req_ready;
  logic [ADDR_W-1:0] in_addr;
  logic              in_write;
  logic [31:0]       in_wdata;
  logic [3:0]        in_wstrb;
  logic              in_resp_valid;
  logic              in_resp_ready;
  logic [31:0]       in_rdata;
  logic              in_err;
  logic [ADDR_W-1:0] out_paddr;
  logic              out_psel;
  logic              out_penable;
  logic [2:0]        out_pprot;
  logic              out_pwrite;
  logic [31:0]       out_pwdata;
  logic [3:0]        out_pstrb;
  logic              out_pready;
  logic [31:0]       out_prdata;
  logic              out_pslverr;

  modport master (
    input  in_req_valid,
    input  in_addr,
    input  in_write,
    input  in_wdata,
    input  in_wstrb,
    input  in_resp_ready,
    input  out_pready,
    input  out_prdata,
    input  out_pslverr,
    output in_req_ready,
    output in_resp_valid,
    output in_rdata,
    output in_err,
    output out_paddr,
    output out_psel,
    output out_penable,
    output out_pprot,
    output out_pwrite,
    output out_pwdata,
    output out_pstrb
  );

  modport slave (
    output in_req_valid,
    output in_addr,
    output in_write,
    output in_wdata,
    output in_wstrb,
    output in_resp_ready,
    output out_pready,
    output out_prdata,
    output out_pslverr,
    input  in_req_ready,
    input  in_resp_valid,
    input  in_rdata,
    input  in_err,
    input  out_paddr,
    input  out_psel,
    input  out_penable,
    input  out_pprot,
    input  out_pwrite,
    input  out_pwdata,
    input  out_pstrb
  );
endinterface

// File: rtl/apb_initiator_bridge.sv
// Single-outstanding APB initiator: valid/ready request in, SETUP/ACCESS
// transfer out, registered response back, with an ACCESS wait timeout.
module apb_initiator_bridge #(
  parameter int          ADDR_W  = 32,
  parameter int          TIMEOUT = 256,
  parameter logic [2:0]  PPROT   = 3'b000
) (
  input  logic                  clock,
  input  logic                  reset,
  apb_initiator_bridge_if.master bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [3:0]        pstrb_q, pstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == LIMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_req_valid) begin
          paddr_d  = bus.in_addr;
          pwdata_d = bus.in_wdata;
          pwrite_d = bus.in_write;
          pstrb_d  = bus.in_write ? bus.in_wstrb : 4'b0000;
          cnt_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // A ready responder wins even in the cycle the timeout would fire.
        if (bus.out_pready) begin
          rdata_d = pwrite_q ? 32'h0 : bus.out_prdata;
          err_d   = bus.out_pslverr;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (bus.in_resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_req_ready  = reset && (state_q == S_IDLE);
  assign bus.in_resp_valid = (state_q == S_RESP);
  assign bus.in_rdata      = rdata_q;
  assign bus.in_err        = err_q;
  assign bus.out_psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign bus.out_penable   = (state_q == S_ACCESS);
  assign bus.out_pprot     = PPROT;
  assign bus.out_paddr     = paddr_q;
  assign bus.out_pwrite    = pwrite_q;
  assign bus.out_pwdata    = pwdata_q;
  assign bus.out_pstrb     = pstrb_q;

endmodule

// File: tb/tb_apb_initiator_bridge.sv
// Randomized bench for apb_initiator_bridge against a transaction-level model;
// one instance with the default timeout, one with TIMEOUT=4.
module tb_apb_initiator_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, write, resp_ready, pready, pslverr;
  logic [31:0] addr, wdata, prdata;
  logic [3:0]  wstrb;
  bit          sel;

  logic        o_req_ready, o_resp_valid, o_err, o_psel, o_penable, o_pwrite;
  logic [31:0] o_rdata, o_paddr, o_pwdata;
  logic [3:0]  o_pstrb;
  logic [2:0]  o_pprot;

  apb_initiator_bridge_if #(.ADDR_W(32)) bus_a ();
  apb_initiator_bridge_if #(.ADDR_W(32)) bus_b ();

  apb_initiator_bridge #(.ADDR_W(32)) dut_a (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_a)
  );

  apb_initiator_bridge #(
    .ADDR_W (32),
    .TIMEOUT(4),
    .PPROT  (3'b101)
  ) dut_b (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_b)
  );

  assign bus_a.in_req_valid  = req_valid;
  assign bus_a.in_addr       = addr;
  assign bus_a.in_write      = write;
  assign bus_a.in_wdata      = wdata;
  assign bus_a.in_wstrb      = wstrb;
  assign bus_a.in_resp_ready = resp_ready;
  assign bus_a.out_pready    = pready;
  assign bus_a.out_prdata    = prdata;
  assign bus_a.out_pslverr   = pslverr;
  assign bus_b.in_req_valid  = req_valid;
  assign bus_b.in_addr       = addr;
  assign bus_b.in_write      = write;
  assign bus_b.in_wdata      = wdata;
  assign bus_b.in_wstrb      = wstrb;
  assign bus_b.in_resp_ready = resp_ready;
  assign bus_b.out_pready    = pready;
  assign bus_b.out_prdata    = prdata;
  assign bus_b.out_pslverr   = pslverr;

  always_comb begin
    o_req_ready  = sel ? bus_b.in_req_ready  : bus_a.in_req_ready;
    o_resp_valid = sel ? bus_b.in_resp_valid : bus_a.in_resp_valid;
    o_rdata      = sel ? bus_b.in_rdata      : bus_a.in_rdata;
    o_err        = sel ? bus_b.in_err        : bus_a.in_err;
    o_paddr      = sel ? bus_b.out_paddr     : bus_a.out_paddr;
    o_psel       = sel ? bus_b.out_psel      : bus_a.out_psel;
    o_penable    = sel ? bus_b.out_penable   : bus_a.out_penable;
    o_pprot      = sel ? bus_b.out_pprot     : bus_a.out_pprot;
    o_pwrite     = sel ? bus_b.out_pwrite    : bus_a.out_pwrite;
    o_pwdata     = sel ? bus_b.out_pwdata    : bus_a.out_pwdata;
    o_pstrb      = sel ? bus_b.out_pstrb     : bus_a.out_pstrb;
  end

  int n_chk = 0;
  int n_pass = 0;
  int cur_to;
  logic [2:0] cur_prot;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Transaction-level expectation: ACCESS length and response payload.
  function automatic void model(input bit wr, input int waits,
                                input logic [31:0] prd, input bit serr,
                                output int acc, output logic [31:0] rd,
                                output bit er);
    if (cur_to != 0 && waits + 1 > cur_to) begin
      acc = cur_to;
      rd  = 32'h0;
      er  = 1'b1;
    end else begin
      acc = waits + 1;
      rd  = wr ? 32'h0 : prd;
      er  = serr;
    end
  endfunction

  task automatic xfer(input logic [31:0] a, input bit wr,
                      input logic [31:0] wd, input logic [3:0] st,
                      input int waits, input logic [31:0] prd,
                      input bit serr, input int bp);
    int acc, exp_acc, lat;
    logic [31:0] exp_rd;
    bit exp_er, done, ok;
    model(wr, waits, prd, serr, exp_acc, exp_rd, exp_er);
    @(negedge clk);
    req_valid = 1'b1;
    addr = a;
    write = wr;
    wdata = wd;
    wstrb = st;
    chk("req_ready_idle", o_req_ready, 1);
    @(negedge clk);
    lat = 1;
    addr = $urandom;
    write = $urandom;
    wdata = $urandom;
    wstrb = 4'($urandom);
    chk("setup_sel", {o_psel, o_penable, o_req_ready}, 3'b100);
    chk("setup_addr", o_paddr, a);
    chk("setup_wdata", o_pwdata, wd);
    chk("setup_ctl", {o_pwrite, o_pstrb, o_pprot},
        {wr, (wr ? st : 4'h0), cur_prot});
    acc = 0;
    done = 0;
    ok = 1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (o_psel && o_penable) begin
        acc++;
        if (o_paddr !== a || o_pwdata !== wd || o_pwrite !== wr ||
            o_req_ready !== 1'b0)
          ok = 0;
        pready = (acc == waits + 1);
        prdata = prd;
        pslverr = serr;
      end else begin
        done = 1;
      end
    end
    pready = 1'b0;
    prdata = $urandom;
    pslverr = $urandom;
    chk("access_stable", ok, 1);
    chk("access_cycles", acc, exp_acc);
    chk("resp_latency", lat, exp_acc + 2);
    chk("resp_valid", {o_resp_valid, o_psel, o_penable, o_req_ready}, 4'b1000);
    chk("resp_rdata", o_rdata, exp_rd);
    chk("resp_err", o_err, exp_er);
    ok = 1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (o_resp_valid !== 1'b1 || o_rdata !== exp_rd || o_err !== exp_er ||
          o_psel !== 1'b0 || o_penable !== 1'b0 || o_req_ready !== 1'b0)
        ok = 0;
    end
    if (bp > 0) chk("backpressure", ok, 1);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("back_idle", {o_resp_valid, o_req_ready, o_psel}, 3'b010);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic reset_mid_access();
    bit ok;
    @(negedge clk);
    req_valid = 1'b1;
    addr = 32'h2000_0040;
    write = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_access", {o_psel, o_penable}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {o_psel, o_penable, o_resp_valid, o_req_ready}, 4'b0);
    chk("rst_async_addr", o_paddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1;
    repeat (4) begin
      @(negedge clk);
      if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_psel !== 1'b0)
        ok = 0;
    end
    chk("rst_release_idle", ok, 1);
  endtask

  task automatic rand_xfers(input int n, input int maxw);
    for (int k = 0; k < n; k++)
      xfer($urandom, 1'($urandom), $urandom, 4'($urandom),
           int'($urandom_range(0, maxw)), $urandom, 1'($urandom),
           int'($urandom_range(0, 3)));
  endtask

  initial begin
    sel = 0;
    cur_to = 256;
    cur_prot = 3'b000;
    req_valid = 0;
    write = 0;
    resp_ready = 0;
    pready = 0;
    pslverr = 0;
    addr = 0;
    wdata = 0;
    prdata = 0;
    wstrb = 0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {o_psel, o_penable, o_resp_valid, o_err, o_req_ready}, 5'b0);
    chk("rst_data", {o_paddr, o_rdata}, 64'h0);
    chk("rst_apb", {o_pwdata, o_pwrite, o_pstrb}, 37'h0);
    rst_n = 1'b1;

    xfer(32'h1000_0000, 1, 32'h0000_A5A5, 4'hF, 0, 32'h5555_5555, 0, 0);
    xfer(32'h1000_0004, 0, 32'h0, 4'hF, 5, 32'h0000_1234, 0, 0);
    xfer(32'h1000_0008, 0, 32'h0, 4'h3, 0, 32'hDEAD_BEEF, 1, 0);
    xfer(32'h1000_000C, 0, 32'h0, 4'h0, 2, 32'hCAFE_0001, 0, 10);
    xfer(32'h1000_0010, 0, 32'h0, 4'h0, 20, 32'h0BAD_F00D, 0, 1);
    rand_xfers(20, 6);
    reset_mid_access();
    xfer(32'h1000_0014, 1, 32'h1111_2222, 4'h5, 1, 32'h0, 0, 0);

    sel = 1;
    cur_to = 4;
    cur_prot = 3'b101;
    do_reset();
    xfer(32'h3000_0000, 0, 32'h0, 4'h0, 10, 32'h7777_7777, 0, 2);
    xfer(32'h3000_0004, 0, 32'h0, 4'h0, 3, 32'h0000_4321, 0, 0);
    xfer(32'h3000_0008, 1, 32'hFFFF_0000, 4'hC, 4, 32'h0, 0, 0);
    rand_xfers(25, 6);
    reset_mid_access();
    xfer(32'h3000_000C, 0, 32'h0, 4'h0, 0, 32'h8888_0001, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_initiator_bridge.md
Name: apb_initiator_bridge

Overview:
- Single-outstanding APB initiator that converts a simple valid/ready request channel into APB SETUP/ACCESS transfers, and returns a valid/ready response.
- Sits between a core-side bus adapter and APB responders such as the GPIO, UART and SPI peripherals.
- Provides the driving end of the APB interface those peripherals implement.
- Adds a wait-state timeout so a responder that never raises pready cannot hang the core.

Parameters:
- ADDR_W, 32, width of in_addr and out_paddr.
- TIMEOUT, 256, maximum ACCESS-phase cycles waited for out_pready; 0 disables the timeout.
- PPROT, 3'b000, constant driven on out_pprot.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets immediately, release is synchronous to clock.
- in_req_valid  in  1  request present.
- in_req_ready  out  1  bridge accepts a request this cycle.
- in_addr  in  ADDR_W  byte address.
- in_write  in  1  1 = write, 0 = read.
- in_wdata  in  32  write data.
- in_wstrb  in  4  byte strobes; ignored for reads.
- in_resp_valid  out  1  response present.
- in_resp_ready  in  1  consumer accepts the response.
- in_rdata  out  32  read data; 0 for writes and on timeout.
- in_err  out  1  1 = slave error or timeout.
- out_paddr  out  ADDR_W  APB address.
- out_psel  out  1  APB select.
- out_penable  out  1  APB enable.
- out_pprot  out  3  equals PPROT.
- out_pwrite  out  1  APB direction.
- out_pwdata  out  32  APB write data.
- out_pstrb  out  4  APB strobes; 4'b0000 on reads.
- out_pready  in  1  responder ready.
- out_prdata  in  32  responder read data.
- out_pslverr  in  1  responder error.

Behaviour:
- State machine: IDLE, SETUP, ACCESS, RESP. All outputs are registered or decoded from state and captured registers; there is no combinational path from in_* to out_*.
- Reset (reset=0, at any time, including mid-transfer):
  - State returns to IDLE.
  - out_psel, out_penable, in_resp_valid and in_err go to 0.
  - out_paddr, out_pwdata, out_pwrite, out_pstrb and in_rdata go to 0.
  - The wait counter goes to 0.
  - in_req_ready is 0 while reset is asserted.
  - An in-flight transfer is abandoned with no response.
- IDLE:
  - in_req_ready=1.
  - On in_req_valid&&in_req_ready, capture addr, write, wdata and strb (strb forced to 0 for reads), clear the wait counter, then go to SETUP.
  - in_req_ready is 0 in every other state, so there is exactly one outstanding transfer.
- SETUP (exactly 1 cycle): out_psel=1, out_penable=0, with captured address, data and control stable. Next state is ACCESS.
- ACCESS:
  - out_psel=1, out_penable=1; address, data and control unchanged.
  - If out_pready=1:
    - Capture in_rdata = out_pwrite ? 0 : out_prdata.
    - Capture in_err = out_pslverr.
    - Go to RESP.
  - Otherwise increment the wait counter.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without out_pready, the bridge goes to RESP on the next edge with in_err=1 and in_rdata=0. out_psel and out_penable drop in that same edge.
  - out_pready sampled in the timeout cycle takes priority over the timeout.
- RESP:
  - out_psel=0, out_penable=0; in_resp_valid=1 with stable in_rdata and in_err.
  - On in_resp_ready=1, go to IDLE and clear in_resp_valid.
  - Back-pressure of any length is allowed.
- Minimum request-accept to in_resp_valid latency is 3 cycles: accept edge, SETUP, ACCESS with out_pready=1.
- Back-to-back requests:
  - The minimum issue interval is 4 cycles (IDLE, SETUP, ACCESS, RESP with immediate in_resp_ready).
  - out_psel is low for at least 2 cycles between transfers (RESP and IDLE).
- The wait counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps into a false early timeout.
- in_req_valid changing while the bridge is not in IDLE has no effect.

Test Plan:
- Write, zero-wait: request addr=0x1000_0000, wdata=0x0000_A5A5, strb=4'hF, pready=1 in ACCESS.
  - Required: one SETUP cycle, then one ACCESS cycle.
  - APB fields: out_paddr=0x1000_0000, out_pwdata=0x0000_A5A5, out_pwrite=1.
  - Response: in_resp_valid 3 cycles after accept, in_rdata=0, in_err=0.
- Read with 5 wait states: responder holds pready=0 for 5 ACCESS cycles, then drives pready=1 with prdata=0x0000_1234.
  - Required: ACCESS lasts 6 cycles, then in_rdata=0x0000_1234 and in_err=0.
- Slave error: pslverr=1 together with pready=1 on a read of 0xDEAD_BEEF data.
  - Required: in_err=1 and in_rdata=0xDEAD_BEEF.
- Timeout with TIMEOUT=4: pready held at 0.
  - Required: exactly 4 ACCESS cycles, then psel drops, in_err=1 and in_rdata=0.
  - Second case: pready=1 in the 4th ACCESS cycle gives a normal completion.
- Response back-pressure: hold in_resp_ready=0 for 10 cycles while asserting a second in_req_valid.
  - Required: in_resp_valid and in_rdata stay stable, in_req_ready=0 throughout, psel=0.
  - The second request is accepted only once the bridge is back in IDLE.
- Reset mid-ACCESS: drive reset=0 asynchronously between clock edges.
  - Required: psel, penable and in_resp_valid are 0 immediately.
  - After release the bridge is in IDLE with in_req_ready=1 and no stale response is emitted.
